// File: rtl/cv32e40x_pkg.sv
// Shared eXtension-interface payload types and issue-tracker state encoding.
// All xif ports in the arbiter slice use these typedefs.
package cv32e40x_pkg;

   localparam int unsigned X_ID_WIDTH = 4;
   localparam int unsigned X_DEPTH    = 2 ** X_ID_WIDTH;

   typedef struct packed {
      logic [31:0]           instr;
      logic [X_ID_WIDTH-1:0] id;
   } x_issue_req_t;

   typedef struct packed {
      logic accept;
      logic writeback;
      logic loadstore;
   } x_issue_resp_t;

   typedef struct packed {
      logic [X_ID_WIDTH-1:0] id;
      logic                  commit_kill;
   } x_commit_t;

   typedef struct packed {
      logic [X_ID_WIDTH-1:0] id;
      logic [31:0]           data;
      logic [4:0]            rd;
      logic                  we;
   } x_result_t;

   typedef enum logic {
      ISS_OFFER0 = 1'b0,
      ISS_OFFER1 = 1'b1
   } iss_state_e;

   function automatic logic [X_ID_WIDTH:0] popcnt(logic [X_DEPTH-1:0] v);
      logic [X_ID_WIDTH:0] n;
      n = '0;
      for (int i = 0; i < int'(X_DEPTH); i++) begin
         n = n + {{X_ID_WIDTH{1'b0}}, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/cv32e40x_xif_rr_arb2.sv
// Two-way round-robin arbiter for the result channel.
// Grant is frozen while the winner waits for the core, so it never switches mid-handshake.
module cv32e40x_xif_rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       ack,
   output logic       gnt,
   output logic       gnt_valid,
   output logic [1:0] ready
);

   logic rr;
   logic lock;
   logic held;

   always_comb begin
      if (lock) begin
         gnt = held;
      end else if (req == 2'b11) begin
         gnt = rr;
      end else begin
         gnt = req[1];
      end
   end

   assign gnt_valid = req[gnt];

   always_comb begin
      ready = 2'b00;
      if (!rst) begin
         ready[gnt] = ack;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr   <= 1'b0;
         lock <= 1'b0;
         held <= 1'b0;
      end else if (gnt_valid && ack) begin
         rr   <= ~gnt;
         lock <= 1'b0;
      end else if (gnt_valid) begin
         lock <= 1'b1;
         held <= gnt;
      end
   end

endmodule

// File: rtl/cv32e40x_xif_coproc_arbiter.sv
// Shares one core xif (issue/commit/result) between two coprocessors.
// Issue goes to m0 first, falls back to m1; an id table stalls reuse of in-flight ids.
module cv32e40x_xif_coproc_arbiter
   import cv32e40x_pkg::*;
#(
   parameter int unsigned X_ID_WIDTH = cv32e40x_pkg::X_ID_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_issue_valid,
   output logic                  s_issue_ready,
   input  x_issue_req_t          s_issue_req,
   output x_issue_resp_t         s_issue_resp,
   output logic [1:0]            m_issue_valid,
   input  logic [1:0]            m_issue_ready,
   input  x_issue_resp_t [1:0]   m_issue_resp,
   output x_issue_req_t          m_issue_req,
   input  logic                  s_commit_valid,
   input  x_commit_t             s_commit,
   output logic [1:0]            m_commit_valid,
   output x_commit_t             m_commit,
   input  logic [1:0]            m_result_valid,
   output logic [1:0]            m_result_ready,
   input  x_result_t [1:0]       m_result,
   output logic                  s_result_valid,
   input  logic                  s_result_ready,
   output x_result_t             s_result,
   output logic [X_ID_WIDTH:0]   outstanding
);

   localparam int unsigned DEPTH = 2 ** X_ID_WIDTH;

   iss_state_e       state;
   logic [DEPTH-1:0] tbl_valid;
   logic [DEPTH-1:0] tbl_owner;
   logic [DEPTH-1:0] tbl_valid_n;
   logic [DEPTH-1:0] tbl_owner_n;

   logic             stall;
   logic             alloc;
   logic             rej0;
   logic             kill;
   logic             res_hs;
   logic [1:0]       res_req;
   logic             gnt;
   logic             gnt_valid;

   // Table view is the registered one: a same-cycle clear does not unstall.
   assign stall = tbl_valid[s_issue_req.id];

   always_comb begin
      s_issue_ready = 1'b0;
      s_issue_resp  = '0;
      m_issue_valid = 2'b00;
      rej0          = 1'b0;
      if (!rst) begin
         unique case (state)
            ISS_OFFER0: begin
               m_issue_valid[0] = s_issue_valid & ~stall;
               if (m_issue_valid[0] && m_issue_ready[0]) begin
                  if (m_issue_resp[0].accept) begin
                     s_issue_ready = 1'b1;
                     s_issue_resp  = m_issue_resp[0];
                  end else begin
                     rej0 = 1'b1;
                  end
               end
            end
            ISS_OFFER1: begin
               m_issue_valid[1] = 1'b1;
               if (m_issue_ready[1]) begin
                  s_issue_ready = 1'b1;
                  s_issue_resp  = m_issue_resp[1];
               end
            end
         endcase
      end
   end

   assign m_issue_req = s_issue_req;
   assign alloc       = s_issue_ready & s_issue_resp.accept;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ISS_OFFER0;
      end else begin
         unique case (state)
            ISS_OFFER0: if (rej0) state <= ISS_OFFER1;
            ISS_OFFER1: if (m_issue_ready[1]) state <= ISS_OFFER0;
         endcase
      end
   end

   assign m_commit_valid = {2{s_commit_valid & ~rst}};
   assign m_commit       = s_commit;
   assign kill           = s_commit_valid & s_commit.commit_kill & ~rst;

   assign res_req = rst ? 2'b00 : m_result_valid;

   cv32e40x_xif_rr_arb2 u_rr_arb2 (
      .clk       (clk),
      .rst       (rst),
      .req       (res_req),
      .ack       (s_result_ready),
      .gnt       (gnt),
      .gnt_valid (gnt_valid),
      .ready     (m_result_ready)
   );

   assign s_result_valid = gnt_valid;
   assign s_result       = rst ? '0 : m_result[gnt];
   assign res_hs         = gnt_valid & s_result_ready;

   // Clears first, then allocation; alloc id is never in flight.
   always_comb begin
      tbl_valid_n = tbl_valid;
      tbl_owner_n = tbl_owner;
      if (res_hs) begin
         tbl_valid_n[s_result.id] = 1'b0;
      end
      if (kill) begin
         tbl_valid_n[s_commit.id] = 1'b0;
      end
      if (alloc) begin
         tbl_valid_n[s_issue_req.id] = 1'b1;
         tbl_owner_n[s_issue_req.id] = (state == ISS_OFFER1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tbl_valid   <= '0;
         tbl_owner   <= '0;
         outstanding <= '0;
      end else begin
         tbl_valid   <= tbl_valid_n;
         tbl_owner   <= tbl_owner_n;
         outstanding <= popcnt(tbl_valid_n);
      end
   end

   a_result_owner: assert property (@(posedge clk) disable iff (rst)
      res_hs |-> (tbl_valid[s_result.id] && (tbl_owner[s_result.id] == gnt)));

   a_accept_ls: assert property (@(posedge clk) disable iff (rst)
      alloc |-> !s_issue_resp.loadstore);

   a_outstanding: assert property (@(posedge clk) disable iff (rst)
      outstanding <= (X_ID_WIDTH+1)'(DEPTH));

endmodule

// File: tb/tb_cv32e40x_xif_coproc_arbiter.sv
// Directed bench for the xif coprocessor arbiter with an in-flight id set model.
// Outputs are compared on every falling edge.
module tb_cv32e40x_xif_coproc_arbiter;
   import cv32e40x_pkg::*;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                s_issue_valid;
   logic                s_issue_ready;
   x_issue_req_t        s_issue_req;
   x_issue_resp_t       s_issue_resp;
   logic [1:0]          m_issue_valid;
   logic [1:0]          m_issue_ready;
   x_issue_resp_t [1:0] m_issue_resp;
   x_issue_req_t        m_issue_req;
   logic                s_commit_valid;
   x_commit_t           s_commit;
   logic [1:0]          m_commit_valid;
   x_commit_t           m_commit;
   logic [1:0]          m_result_valid;
   logic [1:0]          m_result_ready;
   x_result_t [1:0]     m_result;
   logic                s_result_valid;
   logic                s_result_ready;
   x_result_t           s_result;
   logic [4:0]          outstanding;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cv32e40x_xif_coproc_arbiter #(.X_ID_WIDTH(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .s_issue_valid  (s_issue_valid),
      .s_issue_ready  (s_issue_ready),
      .s_issue_req    (s_issue_req),
      .s_issue_resp   (s_issue_resp),
      .m_issue_valid  (m_issue_valid),
      .m_issue_ready  (m_issue_ready),
      .m_issue_resp   (m_issue_resp),
      .m_issue_req    (m_issue_req),
      .s_commit_valid (s_commit_valid),
      .s_commit       (s_commit),
      .m_commit_valid (m_commit_valid),
      .m_commit       (m_commit),
      .m_result_valid (m_result_valid),
      .m_result_ready (m_result_ready),
      .m_result       (m_result),
      .s_result_valid (s_result_valid),
      .s_result_ready (s_result_ready),
      .s_result       (s_result),
      .outstanding    (outstanding)
   );

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic x_issue_resp_t rsp(input logic a);
      x_issue_resp_t r;
      r.accept    = a;
      r.writeback = a;
      r.loadstore = 1'b0;
      return r;
   endfunction

   function automatic x_result_t res(input logic [3:0] id);
      x_result_t r;
      r.id   = id;
      r.data = 32'hC0DE_0000 | 32'(id);
      r.rd   = 5'(id) + 5'd1;
      r.we   = 1'b1;
      return r;
   endfunction

   function automatic x_issue_req_t req(input logic [3:0] id);
      x_issue_req_t r;
      r.instr = 32'h0000_000B | (32'(id) << 7);
      r.id    = id;
      return r;
   endfunction

   // Model: set of in-flight ids plus which coprocessor is being offered to.
   bit          infl [16];
   int          phase;
   bit          started = 1'b0;
   logic [1:0]  ev;
   logic        er;
   logic        ok_src;
   int          cnt;
   x_issue_resp_t dr;

   always @(negedge clk) begin
      if (rst) begin
         foreach (infl[i]) infl[i] = 1'b0;
         phase   = 0;
         started = 1'b1;
      end else if (started) begin
         cnt = 0;
         foreach (infl[i]) cnt += int'(infl[i]);
         dr = m_issue_resp[phase];
         if (phase == 0) begin
            ev = {1'b0, s_issue_valid & ~infl[s_issue_req.id]};
            er = ev[0] & m_issue_ready[0] & dr.accept;
         end else begin
            ev = 2'b10;
            er = m_issue_ready[1];
         end
         chk("m_issue_valid", 64'(m_issue_valid), 64'(ev));
         chk("s_issue_ready", 64'(s_issue_ready), 64'(er));
         if (er) chk("s_issue_resp", 64'(s_issue_resp), 64'(dr));
         chk("m_issue_req", 64'(m_issue_req), 64'(s_issue_req));
         chk("m_commit_valid", 64'(m_commit_valid), 64'({2{s_commit_valid}}));
         chk("m_commit", 64'(m_commit), 64'(s_commit));
         chk("outstanding", 64'(outstanding), 64'(cnt));
         chk("s_result_valid", 64'(s_result_valid), 64'(|m_result_valid));
         chk("ready_count", 64'($countones(m_result_ready)), 64'(s_result_ready));
         if (s_result_valid) begin
            ok_src = (m_result_valid[0] && s_result == m_result[0] && m_result_ready[1] == 1'b0)
                  || (m_result_valid[1] && s_result == m_result[1] && m_result_ready[0] == 1'b0);
            chk("result_src", 64'(ok_src), 64'd1);
            if (s_result_ready) infl[s_result.id] = 1'b0;
         end
         if (s_commit_valid && s_commit.commit_kill) infl[s_commit.id] = 1'b0;
         if (er && dr.accept) infl[s_issue_req.id] = 1'b1;
         if (phase == 0 && ev[0] && m_issue_ready[0] && !dr.accept) phase = 1;
         else if (phase == 1 && m_issue_ready[1]) phase = 0;
      end
   end

   task automatic idle();
      s_issue_valid  = 1'b0;
      s_issue_req    = '0;
      m_issue_ready  = 2'b00;
      m_issue_resp   = '0;
      s_commit_valid = 1'b0;
      s_commit       = '0;
      m_result_valid = 2'b00;
      m_result       = '0;
      s_result_ready = 1'b0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic neg();
      @(negedge clk);
   endtask

   task automatic issue(input logic [3:0] id, input logic a0, input logic a1, input logic [1:0] rdy);
      s_issue_valid   = 1'b1;
      s_issue_req     = req(id);
      m_issue_ready   = rdy;
      m_issue_resp[0] = rsp(a0);
      m_issue_resp[1] = rsp(a1);
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_outstanding"}, 64'(outstanding), 64'd0);
      chk({tag, "_s_issue_ready"}, 64'(s_issue_ready), 64'd0);
      chk({tag, "_m_issue_valid"}, 64'(m_issue_valid), 64'd0);
      chk({tag, "_s_result_valid"}, 64'(s_result_valid), 64'd0);
      chk({tag, "_m_result_ready"}, 64'(m_result_ready), 64'd0);
      chk({tag, "_s_issue_resp"}, 64'(s_issue_resp), 64'd0);
      chk({tag, "_s_result"}, 64'(s_result), 64'd0);
   endtask

   initial begin
      idle();
      rst = 1'b1;
      cyc(); cyc();
      rst = 1'b0;
      neg(); reset_checks("rst");

      // m0 accepts id 3 with zero latency
      cyc(); issue(4'd3, 1'b1, 1'b0, 2'b01);
      neg(); chk("t1_mv", 64'(m_issue_valid), 64'b01);
      chk("t1_ready", 64'(s_issue_ready), 64'd1);
      cyc(); idle();
      neg(); chk("t1_out", 64'(outstanding), 64'd1);

      // m0 rejects, m1 accepts id 5
      cyc(); issue(4'd5, 1'b0, 1'b1, 2'b11);
      neg(); chk("t2_mv0", 64'(m_issue_valid), 64'b01);
      chk("t2_ready0", 64'(s_issue_ready), 64'd0);
      cyc();
      neg(); chk("t2_mv1", 64'(m_issue_valid), 64'b10);
      chk("t2_ready1", 64'(s_issue_ready), 64'd1);
      chk("t2_acc", 64'(s_issue_resp.accept), 64'd1);
      cyc(); idle();
      neg(); chk("t2_out", 64'(outstanding), 64'd2);

      // both reject id 7
      cyc(); issue(4'd7, 1'b0, 1'b0, 2'b11);
      neg(); chk("t3_ready0", 64'(s_issue_ready), 64'd0);
      cyc();
      neg(); chk("t3_ready1", 64'(s_issue_ready), 64'd1);
      chk("t3_acc", 64'(s_issue_resp.accept), 64'd0);
      cyc(); idle();
      neg(); chk("t3_out", 64'(outstanding), 64'd2);

      // reissue id 3 while in flight stalls until its result handshakes
      cyc(); issue(4'd3, 1'b1, 1'b0, 2'b01);
      neg(); chk("t4_stall0", 64'(m_issue_valid), 64'b00);
      cyc();
      neg(); chk("t4_stall1", 64'(m_issue_valid), 64'b00);
      cyc(); m_result_valid = 2'b01; m_result[0] = res(4'd3); s_result_ready = 1'b1;
      neg(); chk("t4_res_id", 64'(s_result.id), 64'd3);
      chk("t4_res_rdy", 64'(m_result_ready), 64'b01);
      chk("t4_stall2", 64'(m_issue_valid), 64'b00);
      cyc(); m_result_valid = 2'b00; s_result_ready = 1'b0;
      neg(); chk("t4_mv", 64'(m_issue_valid), 64'b01);
      chk("t4_ready", 64'(s_issue_ready), 64'd1);
      chk("t4_out_mid", 64'(outstanding), 64'd1);
      cyc(); idle();
      neg(); chk("t4_out", 64'(outstanding), 64'd2);

      // kill and result handshake on id 5 in the same cycle
      cyc(); m_result_valid = 2'b10; m_result[1] = res(4'd5); s_result_ready = 1'b1;
      s_commit_valid = 1'b1; s_commit.id = 4'd5; s_commit.commit_kill = 1'b1;
      neg(); chk("t6_res_rdy", 64'(m_result_ready), 64'b10);
      chk("t6_cv", 64'(m_commit_valid), 64'b11);
      cyc(); idle();
      neg(); chk("t6_out", 64'(outstanding), 64'd1);

      // both results valid, rr=0, core stalls 3 cycles
      cyc(); issue(4'd9, 1'b0, 1'b1, 2'b11);
      cyc();
      cyc(); idle();
      neg(); chk("t5_out0", 64'(outstanding), 64'd2);
      cyc(); m_result_valid = 2'b11; m_result[0] = res(4'd3); m_result[1] = res(4'd9);
      for (int i = 0; i < 3; i++) begin
         neg(); chk("t5_hold_id", 64'(s_result.id), 64'd3);
         chk("t5_hold_rdy", 64'(m_result_ready), 64'b00);
         cyc();
      end
      s_result_ready = 1'b1;
      neg(); chk("t5_hs0_rdy", 64'(m_result_ready), 64'b01);
      cyc(); m_result_valid = 2'b10;
      neg(); chk("t5_hs1_id", 64'(s_result.id), 64'd9);
      chk("t5_hs1_rdy", 64'(m_result_ready), 64'b10);
      cyc(); idle();
      neg(); chk("t5_out", 64'(outstanding), 64'd0);

      // lock keeps m1 granted after m0 shows up mid-handshake
      cyc(); issue(4'd1, 1'b1, 1'b0, 2'b01);
      cyc(); issue(4'd2, 1'b0, 1'b1, 2'b11);
      cyc();
      cyc(); idle();
      cyc(); m_result_valid = 2'b10; m_result[1] = res(4'd2);
      neg(); chk("lk_id0", 64'(s_result.id), 64'd2);
      cyc(); m_result_valid = 2'b11; m_result[0] = res(4'd1);
      neg(); chk("lk_id1", 64'(s_result.id), 64'd2);
      cyc(); s_result_ready = 1'b1;
      neg(); chk("lk_rdy", 64'(m_result_ready), 64'b10);
      cyc(); m_result_valid = 2'b01;
      neg(); chk("lk_next_id", 64'(s_result.id), 64'd1);
      cyc(); idle();
      neg(); chk("lk_out", 64'(outstanding), 64'd0);

      // reset while stuck in OFFER1 discards the offer and the table
      cyc(); issue(4'd4, 1'b1, 1'b0, 2'b01);
      cyc(); idle();
      neg(); chk("r_out0", 64'(outstanding), 64'd1);
      cyc(); issue(4'd2, 1'b0, 1'b0, 2'b01);
      neg(); chk("r_ready0", 64'(s_issue_ready), 64'd0);
      cyc(); m_issue_ready = 2'b00;
      neg(); chk("r_offer1", 64'(m_issue_valid), 64'b10);
      cyc(); rst = 1'b1;
      neg(); chk("r_during", 64'(m_issue_valid), 64'b00);
      cyc(); rst = 1'b0; idle();
      neg(); reset_checks("r_after");
      chk("r_cv", 64'(m_commit_valid), 64'b00);
      cyc(); issue(4'd4, 1'b1, 1'b0, 2'b01);
      neg(); chk("r_reissue_mv", 64'(m_issue_valid), 64'b01);
      chk("r_reissue_rdy", 64'(s_issue_ready), 64'd1);
      cyc(); idle();
      neg(); chk("r_out1", 64'(outstanding), 64'd1);

      cyc();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
